// File: rtl/fetch_unit_pkg.sv
// Shared encodings for the fetch front-end: PCSrc select, fetch FSM states,
// branch strobe bit positions and the default reset PC.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        PCSRC_SEQ = 2'b00,
        PCSRC_BR  = 2'b01,
        PCSRC_JMP = 2'b10,
        PCSRC_JR  = 2'b11
    } pcsrc_e;

    typedef enum logic [1:0] {
        F_IDLE = 2'b00,
        F_REQ  = 2'b01,
        F_WAIT = 2'b10
    } fetch_state_e;

    localparam int BR_BEQ = 0;
    localparam int BR_BNE = 1;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    function automatic logic [31:0] jump_target(input logic [3:0] pc_hi, input logic [25:0] jidx);
        return {pc_hi, jidx, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus with a variable-latency ready strobe.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;

    modport master (output imem_req, imem_addr, input imem_rdata, imem_ready);
    modport slave  (input imem_req, imem_addr, output imem_rdata, imem_ready);
endinterface

// File: rtl/fetch_unit_pc_next_mux.sv
// Combinational next-PC select and PC write-enable; shared with the datapath.
module pc_next_mux
    import fetch_unit_pkg::*;
(
    input  logic [3:0]  pc_hi,
    input  logic [25:0] jidx,
    input  logic        pc_write,
    input  logic [1:0]  branch,
    input  logic        zero,
    input  logic [1:0]  pc_src,
    input  logic [31:0] alu_result,
    input  logic [31:0] alu_out,
    input  logic [31:0] reg_a,
    output logic [31:0] pc_next,
    output logic        pc_en
);

    assign pc_en = pc_write | (branch[BR_BEQ] & zero) | (branch[BR_BNE] & ~zero);

    always_comb begin
        pc_next = alu_result;
        case (pcsrc_e'(pc_src))
            PCSRC_SEQ: pc_next = alu_result;
            PCSRC_BR:  pc_next = alu_out;
            PCSRC_JMP: pc_next = jump_target(pc_hi, jidx);
            PCSRC_JR:  pc_next = reg_a;
            default:   pc_next = alu_result;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch front-end: PC register, instruction register and IDLE/REQ/WAIT memory FSM.
// Optional macro FETCH_TIMEOUT_EN adds a WAIT timeout with a sticky fetch_err.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = RESET_PC_DEFAULT,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic         cclk,
    input  logic         rst,
    input  logic         fetch_start,
    input  logic         pc_write,
    input  logic [1:0]   branch,
    input  logic         zero,
    input  logic [1:0]   pc_src,
    input  logic [31:0]  alu_result,
    input  logic [31:0]  alu_out,
    input  logic [31:0]  reg_a,
    fetch_unit_if.master imem,
    output logic [31:0]  instr,
    output logic         instr_valid,
    output logic         fetch_busy,
    output logic [31:0]  pc,
    output logic         fetch_err
);

    fetch_state_e state, state_nx;
    logic [31:0]  pc_next;
    logic         pc_en;
    logic [31:0]  req_addr;
    logic         timeout;
    logic         done;

    pc_next_mux u_pc_next_mux (
        .pc_hi      (pc[31:28]),
        .jidx       (instr[25:0]),
        .pc_write   (pc_write),
        .branch     (branch),
        .zero       (zero),
        .pc_src     (pc_src),
        .alu_result (alu_result),
        .alu_out    (alu_out),
        .reg_a      (reg_a),
        .pc_next    (pc_next),
        .pc_en      (pc_en)
    );

    assign done = (state == F_WAIT) && imem.imem_ready;

    always_ff @(posedge cclk or posedge rst) begin
        if (rst) state <= F_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        fetch_busy = 1'b0;
        case (state)
            F_IDLE: if (fetch_start) state_nx = F_REQ;
            F_REQ: begin
                fetch_busy = 1'b1;
                state_nx   = F_WAIT;
            end
            F_WAIT: begin
                fetch_busy = 1'b1;
                if (imem.imem_ready || timeout) state_nx = F_IDLE;
            end
            default: state_nx = F_IDLE;
        endcase
    end

    assign imem.imem_req  = fetch_busy;
    assign imem.imem_addr = req_addr;

    // The request address is frozen at REQ entry so a PC write mid-fetch
    // does not retarget the outstanding access.
    always_ff @(posedge cclk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_PC;
            instr       <= 32'h0;
            instr_valid <= 1'b0;
            req_addr    <= 32'h0;
        end else begin
            instr_valid <= done;
            if (pc_en) pc <= pc_next;
            if (state == F_IDLE && fetch_start) req_addr <= pc;
            if (done) instr <= imem.imem_rdata;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;

    // Fires on the TIMEOUT_CYCLES-th WAIT cycle without a ready strobe.
    assign timeout = (state == F_WAIT) && !imem.imem_ready
                  && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge cclk or posedge rst) begin
        if (rst) begin
            to_cnt    <= '0;
            fetch_err <= 1'b0;
        end else begin
            if (state == F_WAIT && !done && !timeout) to_cnt <= to_cnt + TO_W'(1);
            else                                      to_cnt <= '0;
            if (timeout) fetch_err <= 1'b1;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^TIMEOUT_CYCLES;
    assign timeout    = 1'b0;
    assign fetch_err  = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed and randomized PC updates and fetches
// against a spec-level PC/IR model. Timeout scenario runs when FETCH_TIMEOUT_EN is defined.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          TO     = 16;

    logic        cclk = 1'b0;
    logic        rst;
    logic        fetch_start, pc_write, zero;
    logic [1:0]  branch, pc_src;
    logic [31:0] alu_result, alu_out, reg_a;
    logic [31:0] instr, pc;
    logic        instr_valid, fetch_busy, fetch_err;

    fetch_unit_if imem();

    fetch_unit #(.RESET_PC(RST_PC), .TIMEOUT_CYCLES(TO)) dut (
        .cclk        (cclk),
        .rst         (rst),
        .fetch_start (fetch_start),
        .pc_write    (pc_write),
        .branch      (branch),
        .zero        (zero),
        .pc_src      (pc_src),
        .alu_result  (alu_result),
        .alu_out     (alu_out),
        .reg_a       (reg_a),
        .imem        (imem),
        .instr       (instr),
        .instr_valid (instr_valid),
        .fetch_busy  (fetch_busy),
        .pc          (pc),
        .fetch_err   (fetch_err)
    );

    always #5 cclk = ~cclk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] m_pc, m_instr;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge cclk);
        #1;
    endtask

    task automatic idle_inputs();
        fetch_start     = 1'b0;
        pc_write        = 1'b0;
        branch          = 2'b00;
        zero            = 1'b0;
        pc_src          = 2'b00;
        alu_result      = 32'h0;
        alu_out         = 32'h0;
        reg_a           = 32'h0;
        imem.imem_ready = 1'b0;
        imem.imem_rdata = 32'h0;
    endtask

    // Reference: the PC is written when any strobe condition holds; value chosen by pc_src.
    function automatic logic [31:0] ref_pc(input logic [31:0] cur, input logic [31:0] ins,
                                           input logic pw, input logic [1:0] br, input logic z,
                                           input logic [1:0] src, input logic [31:0] ar,
                                           input logic [31:0] ao, input logic [31:0] ra);
        bit take;
        take = pw || (br[0] && z) || (br[1] && !z);
        if (!take) return cur;
        case (src)
            2'd0:    return ar;
            2'd1:    return ao;
            2'd2:    return (cur & 32'hF000_0000) + ((ins & 32'h03FF_FFFF) * 4);
            default: return ra;
        endcase
    endfunction

    task automatic pc_op(input logic pw, input logic [1:0] br, input logic z, input logic [1:0] src,
                         input logic [31:0] ar, input logic [31:0] ao, input logic [31:0] ra);
        pc_write = pw; branch = br; zero = z; pc_src = src;
        alu_result = ar; alu_out = ao; reg_a = ra;
        tick();
        idle_inputs();
        m_pc = ref_pc(m_pc, m_instr, pw, br, z, src, ar, ao, ra);
    endtask

    task automatic set_pc(input logic [31:0] v);
        pc_op(1'b1, 2'b00, 1'b0, 2'b00, v, 32'h0, 32'h0);
    endtask

    // Stimulus only: one fetch with `lat` idle WAIT cycles before ready.
    task automatic run_fetch(input logic [31:0] data, input int lat, output logic [31:0] addr_seen,
                             output bit early, output bit on_time, output int vcnt);
        early = 0;
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        addr_seen = imem.imem_addr;
        if (instr_valid) early = 1;
        tick();
        if (instr_valid) early = 1;
        for (int i = 0; i < lat; i++) begin
            tick();
            if (instr_valid) early = 1;
        end
        imem.imem_rdata = data;
        imem.imem_ready = 1'b1;
        tick();
        imem.imem_ready = 1'b0;
        on_time = instr_valid;
        vcnt = 0;
        for (int i = 0; i < 3; i++) begin
            if (instr_valid) vcnt++;
            tick();
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        #3;
        n_cmp++; if (pc !== RST_PC) begin n_err++; $display("FAIL reset_pc: got %h want %h", pc, RST_PC); end
        n_cmp++; if (instr !== 32'h0) begin n_err++; $display("FAIL reset_instr: got %h want 0", instr); end
        n_cmp++; if ({instr_valid, imem.imem_req, fetch_busy, fetch_err} !== 4'b0)
            begin n_err++; $display("FAIL reset_flags: got %b want 0000", {instr_valid, imem.imem_req, fetch_busy, fetch_err}); end
        n_cmp++; if (imem.imem_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr: got %h want 0", imem.imem_addr); end
        tick(); tick();
        rst = 1'b0;
        m_pc = RST_PC;
        m_instr = 32'h0;
        tick();
    endtask

    task automatic test_fetch_basic();
        logic [31:0] a; bit e, ot; int vc;
        run_fetch(32'h2008_0005, 0, a, e, ot, vc);
        m_instr = 32'h2008_0005;
        n_cmp++; if (a !== 32'h0) begin n_err++; $display("FAIL basic_addr: got %h want 0", a); end
        n_cmp++; if (instr !== m_instr) begin n_err++; $display("FAIL basic_instr: got %h want %h", instr, m_instr); end
        n_cmp++; if ({e, ot} !== 2'b01) begin n_err++; $display("FAIL basic_timing: early=%0d on_time=%0d want 0/1", e, ot); end
        n_cmp++; if (vc !== 1) begin n_err++; $display("FAIL basic_pulse: got %0d cycles want 1", vc); end
        n_cmp++; if (imem.imem_req !== 1'b0) begin n_err++; $display("FAIL basic_req_drop: got %b want 0", imem.imem_req); end
    endtask

    task automatic test_pc_update();
        set_pc(32'h8);
        n_cmp++; if (pc !== m_pc) begin n_err++; $display("FAIL pcw: got %h want %h", pc, m_pc); end
        pc_op(1'b0, 2'b01, 1'b1, 2'b01, 32'h0, 32'h40, 32'h0);
        n_cmp++; if (pc !== 32'h40) begin n_err++; $display("FAIL beq_taken: got %h want 00000040", pc); end
        set_pc(32'h8);
        pc_op(1'b0, 2'b01, 1'b0, 2'b01, 32'h0, 32'h40, 32'h0);
        n_cmp++; if (pc !== 32'h8) begin n_err++; $display("FAIL beq_not_taken: got %h want 00000008", pc); end
        pc_op(1'b0, 2'b10, 1'b0, 2'b01, 32'h0, 32'h40, 32'h0);
        n_cmp++; if (pc !== 32'h40) begin n_err++; $display("FAIL bne_taken: got %h want 00000040", pc); end
        for (int i = 0; i < 40; i++) begin
            pc_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), $urandom, $urandom, $urandom);
            n_cmp++; if (pc !== m_pc) begin n_err++; $display("FAIL pc_rand[%0d]: got %h want %h", i, pc, m_pc); end
        end
    endtask

    task automatic test_jump();
        logic [31:0] a; bit e, ot; int vc;
        set_pc(32'h1000_0000);
        run_fetch(32'h0800_0010, 1, a, e, ot, vc);
        m_instr = 32'h0800_0010;
        n_cmp++; if (a !== 32'h1000_0000) begin n_err++; $display("FAIL jmp_fetch_addr: got %h want 10000000", a); end
        pc_op(1'b1, 2'b00, 1'b0, 2'b10, $urandom, $urandom, $urandom);
        n_cmp++; if (pc !== 32'h1000_0040) begin n_err++; $display("FAIL jump: got %h want 10000040", pc); end
        pc_op(1'b1, 2'b00, 1'b0, 2'b11, $urandom, $urandom, 32'h88);
        n_cmp++; if (pc !== 32'h88) begin n_err++; $display("FAIL jr: got %h want 00000088", pc); end
    endtask

    task automatic test_fetch_random();
        logic [31:0] a, d; bit e, ot; int vc, lat;
        for (int i = 0; i < 10; i++) begin
            set_pc($urandom & 32'hFFFF_FFFC);
            d = $urandom;
            lat = $urandom_range(0, 5);
            run_fetch(d, lat, a, e, ot, vc);
            m_instr = d;
            n_cmp++; if (a !== m_pc) begin n_err++; $display("FAIL rf_addr[%0d]: got %h want %h", i, a, m_pc); end
            n_cmp++; if (instr !== d) begin n_err++; $display("FAIL rf_instr[%0d]: got %h want %h", i, instr, d); end
            n_cmp++; if ({e, ot, vc[1:0]} !== 4'b0101) begin n_err++; $display("FAIL rf_valid[%0d]: early=%0d on_time=%0d pulses=%0d want 0/1/1", i, e, ot, vc); end
            n_cmp++; if (pc !== m_pc) begin n_err++; $display("FAIL rf_pc[%0d]: got %h want %h", i, pc, m_pc); end
        end
    endtask

    task automatic test_ready_ignored();
        imem.imem_rdata = 32'hDEAD_BEEF;
        imem.imem_ready = 1'b1;
        tick();
        imem.imem_ready = 1'b0;
        n_cmp++; if ({instr_valid, fetch_busy} !== 2'b00 || instr !== m_instr)
            begin n_err++; $display("FAIL ready_idle: valid=%b busy=%b instr=%h want 0/0/%h", instr_valid, fetch_busy, instr, m_instr); end
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        imem.imem_rdata = 32'h1111_2222;
        imem.imem_ready = 1'b1;
        tick();
        n_cmp++; if ({instr_valid, fetch_busy} !== 2'b01 || instr !== m_instr)
            begin n_err++; $display("FAIL ready_in_req: valid=%b busy=%b instr=%h want 0/1/%h", instr_valid, fetch_busy, instr, m_instr); end
        imem.imem_rdata = 32'h3333_4444;
        tick();
        imem.imem_ready = 1'b0;
        m_instr = 32'h3333_4444;
        n_cmp++; if (instr_valid !== 1'b1 || instr !== m_instr)
            begin n_err++; $display("FAIL ready_in_wait: valid=%b instr=%h want 1/%h", instr_valid, instr, m_instr); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] a; bit e, ot; int vc, reqs;
        set_pc(32'h100);
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        tick();
        fetch_start = 1'b1;
        pc_write = 1'b1; pc_src = 2'b00; alu_result = 32'h4;
        tick();
        idle_inputs();
        m_pc = 32'h4;
        n_cmp++; if (pc !== 32'h4) begin n_err++; $display("FAIL b2b_pc: got %h want 00000004", pc); end
        n_cmp++; if (imem.imem_addr !== 32'h100 || imem.imem_req !== 1'b1)
            begin n_err++; $display("FAIL b2b_inflight: addr=%h req=%b want 00000100/1", imem.imem_addr, imem.imem_req); end
        imem.imem_rdata = 32'hABCD_0123;
        imem.imem_ready = 1'b1;
        tick();
        imem.imem_ready = 1'b0;
        m_instr = 32'hABCD_0123;
        n_cmp++; if (instr !== m_instr || instr_valid !== 1'b1)
            begin n_err++; $display("FAIL b2b_data: instr=%h valid=%b want %h/1", instr, instr_valid, m_instr); end
        reqs = 0;
        for (int i = 0; i < 4; i++) begin
            if (imem.imem_req) reqs++;
            tick();
        end
        n_cmp++; if (reqs !== 0) begin n_err++; $display("FAIL b2b_second_req: got %0d req cycles want 0", reqs); end
        run_fetch(32'h5555_AAAA, 2, a, e, ot, vc);
        m_instr = 32'h5555_AAAA;
        n_cmp++; if (a !== 32'h4) begin n_err++; $display("FAIL b2b_next_addr: got %h want 00000004", a); end
    endtask

    task automatic test_reset_mid_wait();
        int vseen;
        set_pc(32'h200);
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (pc !== RST_PC || imem.imem_req !== 1'b0 || fetch_busy !== 1'b0)
            begin n_err++; $display("FAIL rst_mid_wait: pc=%h req=%b busy=%b want %h/0/0", pc, imem.imem_req, fetch_busy, RST_PC); end
        #3 rst = 1'b0;
        m_pc = RST_PC;
        m_instr = 32'h0;
        imem.imem_rdata = 32'hFFFF_0000;
        imem.imem_ready = 1'b1;
        vseen = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (instr_valid) vseen++;
        end
        imem.imem_ready = 1'b0;
        n_cmp++; if (vseen !== 0 || instr !== 32'h0)
            begin n_err++; $display("FAIL rst_no_valid: pulses=%0d instr=%h want 0/00000000", vseen, instr); end
    endtask

`ifdef FETCH_TIMEOUT_EN
    task automatic test_timeout();
        bit early_err;
        fetch_start = 1'b1;
        tick();
        fetch_start = 1'b0;
        tick();
        early_err = 0;
        for (int i = 0; i < TO - 1; i++) begin
            tick();
            if (fetch_err || !fetch_busy) early_err = 1;
        end
        n_cmp++; if (early_err) begin n_err++; $display("FAIL to_early: err or idle before %0d WAIT cycles", TO); end
        tick();
        n_cmp++; if ({fetch_err, fetch_busy, imem.imem_req, instr_valid} !== 4'b1000 || instr !== m_instr)
            begin n_err++; $display("FAIL to_fire: err/busy/req/valid=%b instr=%h want 1000/%h",
                {fetch_err, fetch_busy, imem.imem_req, instr_valid}, instr, m_instr); end
        for (int i = 0; i < 5; i++) tick();
        n_cmp++; if (fetch_err !== 1'b1) begin n_err++; $display("FAIL to_sticky: got %b want 1", fetch_err); end
        rst = 1'b1;
        #2;
        n_cmp++; if (fetch_err !== 1'b0) begin n_err++; $display("FAIL to_rst_clear: got %b want 0", fetch_err); end
        rst = 1'b0;
        m_pc = RST_PC;
        m_instr = 32'h0;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_fetch_basic();
        test_pc_update();
        test_jump();
        test_fetch_random();
        test_ready_ignored();
        test_back_to_back();
        test_reset_mid_wait();
`ifdef FETCH_TIMEOUT_EN
        test_timeout();
`else
        n_cmp++; if (fetch_err !== 1'b0) begin n_err++; $display("FAIL err_tied: got %b want 0", fetch_err); end
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Front-end stage of the multicycle MIPS core, directly upstream of the control FSM.
- Owns the PC register and the instruction register (IR), and drives instruction-memory requests with a variable-latency ready handshake.
- Supplies the stable `instr` word that the controller decodes.
- Applies the controller's PC-update strobes: PCWrite, 2-bit Branch {bne,beq} and PCSrc.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT_CYCLES, 16, cycles WAIT may last before fetch_err; used only with FETCH_TIMEOUT_EN.

Ports:
- cclk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- fetch_start  in  1  controller pulse requesting an instruction fetch at current pc
- pc_write  in  1  unconditional PC write enable
- branch  in  2  [0]=beq (write if zero), [1]=bne (write if !zero)
- zero  in  1  ALU zero flag
- pc_src  in  2  00 alu_result, 01 alu_out, 10 jump target, 11 reg_a (jr)
- alu_result  in  32  combinational ALU output (pc+4 path)
- alu_out  in  32  registered ALU output (branch target)
- reg_a  in  32  register-file read A (jr target)
- imem_req  out  1  memory request, held until accepted
- imem_addr  out  32  request address
- imem_rdata  in  32  read data, valid when imem_ready=1
- imem_ready  in  1  memory completion strobe
- instr  out  32  instruction register
- instr_valid  out  1  one-cycle pulse when IR is loaded
- fetch_busy  out  1  high in REQ/WAIT; controller holds its state while high
- pc  out  32  current PC
- fetch_err  out  1  sticky timeout flag (0 when feature compiled out)

Behaviour:
- Reset (async, any state): pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, imem_addr=0, fetch_busy=0, fetch_err=0, FSM=IDLE, timeout counter=0.
- PC update:
  - pc_en = pc_write | (branch[0]&zero) | (branch[1]&~zero).
  - The next pc is selected by pc_src. The jump target is {pc[31:28], instr[25:0], 2'b00}.
  - The PC is written on the edge where pc_en=1, independent of FSM state.
- FSM IDLE -> REQ on fetch_start. In REQ, imem_req=1 and imem_addr=pc, latched at entry.
- REQ -> WAIT on the next edge; imem_req stays 1 in WAIT.
- WAIT -> IDLE on imem_ready:
  - instr <= imem_rdata.
  - instr_valid=1 for exactly the following cycle.
  - imem_req drops the same edge.
- imem_ready sampled in REQ is ignored; minimum fetch latency is 2 cycles from fetch_start to instr_valid.
- fetch_start outside IDLE is ignored and produces no second request.
- pc_en asserted during REQ/WAIT updates pc but not the in-flight imem_addr. The fetched word belongs to the old address.
- instr holds its value between fetches, so the controller may decode it across all of its states.
- imem_ready in IDLE is ignored.
- fetch_busy = (state==REQ)|(state==WAIT).

Optional Feature:
- FETCH_TIMEOUT_EN defined:
  - A counter increments each WAIT cycle and clears on leaving WAIT.
  - When it reaches TIMEOUT_CYCLES, fetch_err is set (sticky until rst), the FSM returns to IDLE and imem_req drops.
  - instr_valid is not pulsed and instr is unchanged.
- FETCH_TIMEOUT_EN undefined: no counter, fetch_err tied 0, and WAIT waits indefinitely.

Decomposition:
- Shared package/include:
  - PCSrc encodings (PCSRC_SEQ, PCSRC_BR, PCSRC_JMP, PCSRC_JR).
  - Fetch FSM state encodings.
  - Branch bit indices.
  - RESET_PC default.
- One natural sub-module: pc_next_mux, the combinational PCSrc select plus pc_en logic. It is reused by the datapath.
- The FSM, IR and timeout counter stay in fetch_unit.

Test Plan:
- Reset with rst mid-WAIT -> pc=RESET_PC, imem_req=0, fetch_busy=0 immediately, with no instr_valid afterwards.
- fetch_start at pc=0x0, imem_ready one cycle after REQ with rdata=0x20080005 -> imem_addr=0x0, instr=0x20080005, instr_valid single pulse 2 cycles after fetch_start.
- PC update cases:
  - branch=01, zero=1, pc_src=01, alu_out=0x40 -> pc=0x40.
  - Same with zero=0 -> pc unchanged.
  - branch=10, zero=0 -> pc=0x40.
- pc_src=10 with pc=0x1000_0000, instr=0x0800_0010 -> pc=0x1000_0040. pc_src=11, reg_a=0x88 -> pc=0x88.
- Second fetch_start during WAIT plus pc_write to 0x4 -> one request only at the old address, pc=0x4, and the next fetch uses 0x4.
- With FETCH_TIMEOUT_EN and imem_ready never asserted -> fetch_err=1 after 16 WAIT cycles, FSM IDLE, instr unchanged, fetch_err held until rst.
